// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg
//   Shared definitions for the bit-serial subtractor.
//   - ST_IDLE / ST_RUN / ST_DONE : state encodings used by the top-level FSM
//   - state_t                    : enumerated state type built on those encodings
//   - clog2()                    : width of the bit counter for a given operand width
package serial_sub_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_t;

    // Smallest r with 2**r >= value; at least 1 so the counter is never zero-width.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// full_subtractor
//   Combinational one-bit subtractor cell: computes a - b - bin.
//   Ports:
//     a    in  minuend bit
//     b    in  subtrahend bit
//     bin  in  borrow in
//     d    out difference bit
//     bout out borrow out
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial WIDTH-bit subtractor, diff = a - b (mod 2**WIDTH), LSB first,
//   one bit per clock, with a start/busy/done handshake.
//   Ports:
//     clk    in  clock, rising edge
//     rst    in  asynchronous active-high reset
//     start  in  request; honoured only in IDLE or DONE
//     a, b   in  minuend / subtrahend, captured on the accepting edge
//     busy   out high while bits are being processed
//     done   out one-cycle pulse, result valid
//     diff   out result, held until the next operation completes
//     borrow out final borrow (a < b unsigned)
//     ovf    out signed overflow, present only when SERIAL_SUBTRACTOR_OVF_EN is defined
//   Optional feature macro: SERIAL_SUBTRACTOR_OVF_EN
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    output logic             ovf,
`endif
    output logic             borrow
);

    localparam int CW = clog2(WIDTH);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_sh_reg, b_sh_reg, res_sh_reg;
    logic [WIDTH-1:0] res_sh_next;
    logic [CW-1:0]    cnt_reg;
    logic             bor_reg;
    logic [WIDTH-1:0] diff_reg;
    logic             borrow_reg;
    logic             bit_d, bit_bout;
    logic             accept, last_bit;

    full_subtractor u_cell (
        .a    (a_sh_reg[0]),
        .b    (b_sh_reg[0]),
        .bin  (bor_reg),
        .d    (bit_d),
        .bout (bit_bout)
    );

    assign accept   = start && (state_reg == S_IDLE || state_reg == S_DONE);
    assign last_bit = (cnt_reg == CW'(WIDTH - 1));

    // New bit enters at the MSB; after WIDTH shifts the LSB has reached bit 0.
    assign res_sh_next = {bit_d, {(WIDTH-1){1'b0}}} | (res_sh_reg >> 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN:   if (last_bit) state_next = S_DONE;
            S_DONE:  state_next = start ? S_RUN : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            res_sh_reg <= '0;
            cnt_reg    <= '0;
            bor_reg    <= 1'b0;
            diff_reg   <= '0;
            borrow_reg <= 1'b0;
        end else if (accept) begin
            a_sh_reg   <= a;
            b_sh_reg   <= b;
            res_sh_reg <= '0;
            cnt_reg    <= '0;
            bor_reg    <= 1'b0;
        end else if (state_reg == S_RUN) begin
            a_sh_reg   <= a_sh_reg >> 1;
            b_sh_reg   <= b_sh_reg >> 1;
            res_sh_reg <= res_sh_next;
            bor_reg    <= bit_bout;
            cnt_reg    <= cnt_reg + 1'b1;
            // Only the completed word is published, so diff never shows partial shifts.
            if (last_bit) begin
                diff_reg   <= res_sh_next;
                borrow_reg <= bit_bout;
            end
        end
    end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic ovf_reg;

    // On the final bit a_sh/b_sh[0] hold the operand sign bits and bit_d is the result sign.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_reg <= 1'b0;
        end else if (!accept && state_reg == S_RUN && last_bit) begin
            ovf_reg <= (a_sh_reg[0] ^ b_sh_reg[0]) & (bit_d ^ a_sh_reg[0]);
        end
    end

    assign ovf = ovf_reg;
`endif

    assign busy   = (state_reg == S_RUN);
    assign done   = (state_reg == S_DONE);
    assign diff   = diff_reg;
    assign borrow = borrow_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Scoreboard bench for serial_subtractor (WIDTH = 8). The stimulus side pushes
//   the arithmetic expectation for every accepted operation; a monitor pops and
//   compares on each done pulse, including latency and busy-cycle count.
//   Also exercises the full_subtractor cell over its 8-row truth table.
//   Honours SERIAL_SUBTRACTOR_OVF_EN for the ovf port.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         busy, done, borrow;
    logic [W-1:0] diff;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic         ovf;
`endif

    logic fs_a, fs_b, fs_bin, fs_d, fs_bout;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        .ovf    (ovf),
`endif
        .borrow (borrow)
    );

    full_subtractor u_fs (
        .a    (fs_a),
        .b    (fs_b),
        .bin  (fs_bin),
        .d    (fs_d),
        .bout (fs_bout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] diff;
        logic         borrow;
        logic         ovf;
        int           edge_n;
    } exp_t;

    exp_t         sb_q[$];
    exp_t         mon_e;
    int           total = 0;
    int           bad = 0;
    int           busy_cnt = 0;
    logic [W-1:0] last_diff = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Reference: plain unsigned/signed arithmetic on the captured operands.
    task automatic push(input logic [W-1:0] av, input logic [W-1:0] bv);
        exp_t e;
        int   sa, sb, sd;
        sa = int'($signed(av));
        sb = int'($signed(bv));
        sd = sa - sb;
        e.diff   = av - bv;
        e.borrow = (av < bv);
        e.ovf    = (sd > 127) || (sd < -128);
        e.edge_n = cyc;
        sb_q.push_back(e);
        $display("issue a=%02h b=%02h expect diff=%02h borrow=%0d edge=%0d", av, bv, e.diff, e.borrow, cyc);
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    always begin
        @(posedge clk);
        #1;
        if (rst) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done diff=%02h want=no_done", diff);
                end else begin
                    mon_e = sb_q.pop_front();
                    $display("done diff=%02h borrow=%0d (want %02h/%0d) edge=%0d", diff, borrow, mon_e.diff, mon_e.borrow, cyc);
                    check("diff", diff, mon_e.diff);
                    check("borrow", borrow, mon_e.borrow);
                    check("latency_edge", cyc, mon_e.edge_n + W);
                    check("busy_cycles", busy_cnt, W);
                    check("busy_at_done", busy, 1'b0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                    check("ovf", ovf, mon_e.ovf);
`endif
                    last_diff = mon_e.diff;
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv);
        @(negedge clk);
        a = av;
        b = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        push(av, bv);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 60) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL done_timeout pending=%0d want=0", sb_q.size());
            sb_q.delete();
        end
    endtask

    logic [W-1:0] da[6] = '{8'd10, 8'd3,  8'h00, 8'h5A, 8'h80, 8'h05};
    logic [W-1:0] db[6] = '{8'd3,  8'd10, 8'hFF, 8'h5A, 8'h01, 8'h03};

    initial begin
        int r;
        logic [W-1:0] ra, rb;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;

        // Cell truth table: a - b - bin = d - 2*bout
        for (int i = 0; i < 8; i++) begin
            fs_a   = i[2];
            fs_b   = i[1];
            fs_bin = i[0];
            #1;
            r = int'(fs_a) - int'(fs_b) - int'(fs_bin);
            check("fs_d", fs_d, 32'(r & 1));
            check("fs_bout", fs_bout, (r < 0));
        end

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_diff", diff, 8'h00);
        check("rst_borrow", borrow, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Directed operands, each followed by a hold check on diff.
        for (int i = 0; i < 6; i++) begin
            do_op(da[i], db[i]);
            wait_idle();
            repeat (3) @(posedge clk);
            #1;
            check("diff_hold", diff, last_diff);
        end

        // start during RUN must be ignored.
        do_op(8'd20, 8'd5);
        repeat (2) @(negedge clk);
        a = 8'd1;
        b = 8'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (12) @(posedge clk);
        #1;
        check("ignore_diff", diff, 8'h0F);

        // Asynchronous reset mid-RUN: outputs drop before any edge.
        do_op(8'h33, 8'h11);
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        sb_q.delete();
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_done", done, 1'b0);
        check("arst_diff", diff, 8'h00);
        check("arst_borrow", borrow, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(posedge clk);
        do_op(8'd9, 8'd4);
        wait_idle();

        // Back-to-back: start held high, new operands each accept.
        for (int i = 0; i < 6; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            @(negedge clk);
            a = ra;
            b = rb;
            start = 1'b1;
            @(posedge clk);
            #1;
            push(ra, rb);
            repeat (W) @(posedge clk);
        end
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Random single operations with random idle gaps.
        for (int i = 0; i < 20; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            do_op(ra, rb);
            wait_idle();
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        repeat (12) @(posedge clk);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
